// File: rtl/deserialiser_pkg.sv
// rtl/deserialiser_pkg.sv - shared ChaCha word/matrix types for the word-to-block path
package deserialiser_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [31:0] word_t;
  typedef word_t [ROWS-1:0][COLS-1:0] state_t;

endpackage

// File: rtl/deserialiser_if.sv
// rtl/deserialiser_if.sv - word-in / block-out handshake bundle for the deserialiser
interface deserialiser_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  import deserialiser_pkg::*;

  localparam int NUM_WORDS = ROWS * COLS;

  word_t                             indata;
  logic                              validS;
  logic                              in_ready;
  word_t [ROWS-1:0][COLS-1:0]        outdata;
  logic                              out_valid;
  logic                              out_ready;
  logic [$clog2(NUM_WORDS)-1:0]      word_count;

  modport master (
    output indata, validS, out_ready,
    input  in_ready, outdata, out_valid, word_count
  );

  modport slave (
    input  indata, validS, out_ready,
    output in_ready, outdata, out_valid, word_count
  );

endinterface

// File: rtl/deserialiser.sv
// rtl/deserialiser.sv - rebuilds a row-major 4x4 word matrix and holds it behind valid/ready
module deserialiser #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic          clk,
  input  logic          rst,
  deserialiser_if.slave bus
);
  import deserialiser_pkg::*;

  localparam int NUM_WORDS = ROWS * COLS;
  localparam int CW        = $clog2(NUM_WORDS);

  // The final word never lands in acc_reg; it is merged straight into the block.
  logic [CW-1:0]                counter;
  word_t [NUM_WORDS-2:0]        acc_reg;
  word_t [ROWS-1:0][COLS-1:0]   out_reg;
  logic                         out_valid_reg;
  logic                         last_word;
  logic                         in_ready;
  logic                         accept;

  assign last_word = (counter == CW'(NUM_WORDS - 1));
  assign in_ready  = !(last_word && out_valid_reg && !bus.out_ready);
  assign accept    = bus.validS && in_ready;

  assign bus.in_ready   = in_ready;
  assign bus.outdata    = out_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.word_count = counter;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter       <= '0;
      acc_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (accept) begin
        if (last_word) begin
          // Packed layout puts word k at slot [k/COLS][k%COLS].
          out_reg       <= {bus.indata, acc_reg};
          out_valid_reg <= 1'b1;
          counter       <= '0;
        end else begin
          acc_reg[counter] <= bus.indata;
          counter          <= counter + 1'b1;
        end
      end
    end
  end

endmodule
